// File: rtl/ads1292_ecg_packetizer.sv
// ads1292_ecg_packetizer
// Frames each 24-bit filtered ECG sample into a byte packet for the UART transmitter:
// HEADER, SEQ, D[23:16], D[15:8], D[7:0], CKSUM (checksum byte only when CHECKSUM_EN=1).
// The checksum makes bytes SEQ..CKSUM sum to zero mod 256; HEADER is excluded.
// Upstream is held off by withholding ack until the current packet has fully drained.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no packet in flight; a valid sample is captured on the next edge
// ST_SEND | presenting packet bytes to the UART, advancing on valid && ready

module ads1292_ecg_packetizer #(
    parameter logic [7:0] HEADER_BYTE = 8'hAA,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    input  logic [23:0] i_FILTERED_DATA,
    input  logic        i_FILTERED_DATA_VALID,
    output logic        o_FILTERED_DATA_ACK,
    output logic [7:0]  o_TX_DATA,
    output logic        o_TX_DATA_VALID,
    input  logic        i_TX_READY,
    output logic        o_PACKET_DONE,
    output logic        o_BUSY
);

    // Index of the final byte: the checksum slot, or the low data byte without it.
    localparam logic [2:0] LAST_IDX = CHECKSUM_EN ? 3'd5 : 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_q,    state_d;
    logic [23:0] sample_q,   sample_d;
    logic [7:0]  seq_q,      seq_d;
    logic [7:0]  cksum_q,    cksum_d;
    logic [2:0]  idx_q,      idx_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        ack_q,      ack_d;
    logic        done_q,     done_d;

    logic [2:0]  idx_next;
    logic [7:0]  next_byte;

    // Select the packet byte that follows the one currently presented.
    always_comb begin
        idx_next = idx_q + 3'd1;
        case (idx_next)
            3'd1:    next_byte = seq_q;
            3'd2:    next_byte = sample_q[23:16];
            3'd3:    next_byte = sample_q[15:8];
            3'd4:    next_byte = sample_q[7:0];
            3'd5:    next_byte = cksum_q;
            default: next_byte = HEADER_BYTE;
        endcase
    end

    // Next-state and registered-output logic for capture and byte sequencing.
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        seq_d      = seq_q;
        cksum_d    = cksum_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ack_d      = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_FILTERED_DATA_VALID) begin
                    sample_d   = i_FILTERED_DATA;
                    // seq_q does not change until the packet completes, so it is the SEQ byte.
                    cksum_d    = 8'h00 - (seq_q + i_FILTERED_DATA[23:16]
                                          + i_FILTERED_DATA[15:8] + i_FILTERED_DATA[7:0]);
                    ack_d      = 1'b1;
                    tx_data_d  = HEADER_BYTE;
                    tx_valid_d = 1'b1;
                    idx_d      = 3'd0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && i_TX_READY) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        seq_d      = seq_q + 8'd1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d     = idx_next;
                        tx_data_d = next_byte;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q    <= ST_IDLE;
            sample_q   <= 24'h000000;
            seq_q      <= 8'h00;
            cksum_q    <= 8'h00;
            idx_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            seq_q      <= seq_d;
            cksum_q    <= cksum_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
        end
    end

    assign o_FILTERED_DATA_ACK = ack_q;
    assign o_TX_DATA           = tx_data_q;
    assign o_TX_DATA_VALID     = tx_valid_q;
    assign o_PACKET_DONE       = done_q;
    assign o_BUSY              = (state_q == ST_SEND);

endmodule

// File: tb/tb_ads1292_ecg_packetizer.sv
// Bench for ads1292_ecg_packetizer: packet-level model plus directed scenarios.
module tb_ads1292_ecg_packetizer;

    localparam logic [7:0] HDR = 8'hAA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] din;
    logic        din_valid;
    logic        ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        done;
    logic        busy;

    logic [23:0] b_din;
    logic        b_valid;
    logic        b_ack;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid;
    logic        b_ready = 1'b1;
    logic        b_done;
    logic        b_busy;

    always #5 clk = ~clk;

    ads1292_ecg_packetizer #(.HEADER_BYTE(8'hAA), .CHECKSUM_EN(1'b1)) dut (
        .i_CLK(clk), .i_RSTN(rst_n),
        .i_FILTERED_DATA(din), .i_FILTERED_DATA_VALID(din_valid),
        .o_FILTERED_DATA_ACK(ack),
        .o_TX_DATA(tx_data), .o_TX_DATA_VALID(tx_valid), .i_TX_READY(tx_ready),
        .o_PACKET_DONE(done), .o_BUSY(busy)
    );

    ads1292_ecg_packetizer #(.HEADER_BYTE(8'hAA), .CHECKSUM_EN(1'b0)) dut_nock (
        .i_CLK(clk), .i_RSTN(rst_n),
        .i_FILTERED_DATA(b_din), .i_FILTERED_DATA_VALID(b_valid),
        .o_FILTERED_DATA_ACK(b_ack),
        .o_TX_DATA(b_tx_data), .o_TX_DATA_VALID(b_tx_valid), .i_TX_READY(b_ready),
        .o_PACKET_DONE(b_done), .o_BUSY(b_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- packet-level reference model and monitor ----------------
    logic [7:0]  exp_q[$];
    logic [7:0]  cur_pkt[$];
    logic [7:0]  last_pkt[$];
    bit          pkt_open  = 1'b0;
    bit          exp_ack   = 1'b0;
    bit          exp_done  = 1'b0;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  m_seq     = 8'h00;
    logic [7:0]  m_sum;
    logic [23:0] cap_data  = 24'h0;
    int          cyc = 0, cur_first = 0, last_first = 0, last_last = 0;
    int          acc_cnt = 0, done_seen = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {ack, tx_valid, done, busy, tx_data}, 32'h0);
            exp_q.delete();
            cur_pkt.delete();
            pkt_open  = 1'b0;
            exp_ack   = 1'b0;
            exp_done  = 1'b0;
            prev_hold = 1'b0;
            m_seq     = 8'h00;
        end else begin
            check("ack", ack, exp_ack);
            if (ack) begin
                m_sum = m_seq + cap_data[23:16] + cap_data[15:8] + cap_data[7:0];
                exp_q.delete();
                exp_q.push_back(HDR);
                exp_q.push_back(m_seq);
                exp_q.push_back(cap_data[23:16]);
                exp_q.push_back(cap_data[15:8]);
                exp_q.push_back(cap_data[7:0]);
                exp_q.push_back(8'h00 - m_sum);
                cur_pkt.delete();
                pkt_open = 1'b1;
            end
            check("busy", busy, pkt_open);
            check("tx_valid", tx_valid, pkt_open);
            check("packet_done", done, exp_done);
            if (done) done_seen++;
            exp_done = 1'b0;
            if (prev_hold) check("hold_stable", {tx_valid, tx_data}, {1'b1, prev_data});
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            exp_ack  = !pkt_open && din_valid;
            cap_data = din;
            if (tx_valid && tx_ready) begin
                acc_cnt++;
                check("tx_byte", tx_data, (exp_q.size() > 0) ? {24'h0, exp_q[0]} : 32'h100);
                if (cur_pkt.size() == 0) cur_first = cyc;
                cur_pkt.push_back(tx_data);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    pkt_open   = 1'b0;
                    exp_done   = 1'b1;
                    m_seq      = m_seq + 8'd1;
                    last_pkt   = cur_pkt;
                    last_first = cur_first;
                    last_last  = cyc;
                end
            end
        end
    end

    // Second instance (no checksum byte): collect accepted bytes and done pulses.
    logic [7:0] b_bytes[$];
    int         b_done_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && b_tx_valid && b_ready) b_bytes.push_back(b_tx_data);
        if (rst_n && b_done) b_done_cnt++;
    end

    // Ready pattern: 0 holds ready high, 1 toggles every cycle.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) tx_ready = ~tx_ready;
        else tx_ready = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ack();
        int t = 0;
        do begin
            tick();
            t++;
        end while (!ack && t < 40);
        check("ack_arrives", ack, 1);
        din_valid = 1'b0;
    endtask

    task automatic send(input logic [23:0] d);
        din       = d;
        din_valid = 1'b1;
        wait_ack();
    endtask

    task automatic wait_done();
        int base = done_seen;
        int t = 0;
        while (done_seen == base && t < 100) begin
            tick();
            t++;
        end
        check("done_arrives", done_seen - base, 1);
    endtask

    task automatic check_pkt(input string name, input logic [47:0] e);
        check({name, "_len"}, last_pkt.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_b%0d", name, i),
                  (last_pkt.size() > i) ? {24'h0, last_pkt[i]} : 32'h100,
                  {24'h0, e[47-8*i -: 8]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        int t;
        rst_n     = 1'b0;
        din       = 24'h123456;
        din_valid = 1'b1;
        b_din     = 24'h0;
        b_valid   = 1'b0;

        // Reset held with valid and ready high: nothing moves.
        repeat (3) begin
            tick();
            check("rst_no_ack", ack, 0);
            check("rst_no_txv", tx_valid, 0);
        end
        rst_n = 1'b1;
        tick();
        check("first_capture_ack", ack, 1);
        check("first_byte_hdr", tx_data, 8'hAA);
        din_valid = 1'b0;
        wait_done();
        check_pkt("pkt_123456", 48'hAA_00_12_34_56_64);
        check("pkt_123456_span", last_last - last_first, 5);

        // Backpressure with alternating ready.
        do_reset();
        rdy_mode = 1;
        send(24'hFFFFFF);
        wait_done();
        rdy_mode = 0;
        check_pkt("pkt_ffffff_bp", 48'hAA_00_FF_FF_FF_03);

        // New sample while busy: ack held off until the first packet completes.
        base = done_seen;
        send(24'h0A0B0C);
        repeat (2) tick();
        din       = 24'h102030;
        din_valid = 1'b1;
        tick();
        check("midpkt_busy", busy, 1);
        check("midpkt_no_ack", ack, 0);
        wait_ack();
        check("ack_after_done", done_seen - base, 1);
        wait_done();
        check_pkt("pkt_102030_seq2", 48'hAA_02_10_20_30_9E);

        // Sequence counter wrap.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            send(24'h000000);
            wait_done();
            if (i == 255) check_pkt("pkt_seq_ff", 48'hAA_FF_00_00_00_01);
            if (i == 256) check_pkt("pkt_seq_wrap", 48'hAA_00_00_00_00_00);
        end

        // Reset mid-packet after the third byte is accepted.
        do_reset();
        send(24'hABCDEF);
        base = acc_cnt;
        t = 0;
        while (acc_cnt - base < 3 && t < 40) begin
            tick();
            t++;
        end
        check("three_bytes_sent", acc_cnt - base, 3);
        #1 rst_n = 1'b0;
        #1;
        check("abort_txv", tx_valid, 0);
        check("abort_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("no_resume_txv", tx_valid, 0);
        send(24'h000001);
        wait_done();
        check_pkt("pkt_000001", 48'hAA_00_00_00_01_FF);

        // Checksum disabled: 5-byte packet.
        b_bytes.delete();
        b_din   = 24'h000001;
        b_valid = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!b_ack && t < 40);
        check("nock_ack", b_ack, 1);
        b_valid = 1'b0;
        repeat (15) tick();
        check("nock_len", b_bytes.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("nock_b%0d", i),
                  (b_bytes.size() > i) ? {24'h0, b_bytes[i]} : 32'h100,
                  (i == 0) ? 32'hAA : ((i == 4) ? 32'h01 : 32'h00));
        check("nock_done", b_done_cnt, 1);
        check("nock_idle", {b_busy, b_tx_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
